// File: rtl/shift_issue_queue.sv
// Request FIFO and registered result slot placed around the 32-bit combinational
// barrel shifter: the FIFO head drives sh_*, and sh_c is captured into the output slot.
module shift_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [4:0]               in_b,
    input  logic [1:0]               in_aluc,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [31:0]              sh_a,
    output logic [4:0]               sh_b,
    output logic [1:0]               sh_aluc,
    input  logic [31:0]              sh_c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_c,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              done_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 32 + 5 + 2 + TAG_W;

    // Handshakes: a transfer happens at a rising edge where valid && ready are both
    // high; ready never depends on same-cycle valid, and valid holds until accepted.

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [EW-1:0]    head;
    logic             head_valid;
    logic             push;
    logic             load;
    logic             out_fire;

    assign in_ready   = (count != CW'(DEPTH));
    assign head_valid = (count != '0);
    assign push       = in_valid && in_ready && !flush;
    assign load       = head_valid && (!out_valid || out_ready) && !flush;
    assign out_fire   = out_valid && out_ready && !flush;

    assign head    = mem[rd_ptr];
    assign sh_a    = head_valid ? head[EW-1 -: 32]           : 32'd0;
    assign sh_b    = head_valid ? head[EW-33 -: 5]           : 5'd0;
    assign sh_aluc = head_valid ? head[TAG_W+1 -: 2]         : 2'd0;

    // Storage carries no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b, in_aluc, in_tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_c     <= 32'd0;
            out_tag   <= '0;
            done_cnt  <= 16'd0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr    <= rd_ptr + AW'(1);
                out_c     <= sh_c;
                out_tag   <= head[TAG_W-1:0];
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            case ({push, load})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (out_fire) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_shift_issue_queue.sv
// Directed bench for shift_issue_queue with a behavioural barrel shifter on sh_* -> sh_c
// and an expected-result queue checked on every output transfer.
module tb_shift_issue_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int EW    = 32 + TAG_W;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [4:0]       in_b;
    logic [1:0]       in_aluc;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      sh_a;
    logic [4:0]       sh_b;
    logic [1:0]       sh_aluc;
    logic [31:0]      sh_c;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_c;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       count;
    logic [15:0]      done_cnt;
    logic [31:0]      exp_c;

    logic [EW-1:0]    exp_q[$];
    int               n_checks;
    int               n_errors;

    shift_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_aluc(in_aluc), .in_tag(in_tag),
        .sh_a(sh_a), .sh_b(sh_b), .sh_aluc(sh_aluc), .sh_c(sh_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_tag(out_tag),
        .count(count), .done_cnt(done_cnt)
    );

    always_comb begin
        case (sh_aluc)
            2'b00:   sh_c = $unsigned($signed(sh_a) >>> sh_b);
            2'b01:   sh_c = sh_a >> sh_b;
            default: sh_c = sh_a << sh_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard: inputs are stable around the falling edge, so it sees what the next edge commits.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("result_unexpected", {out_tag, out_c}, '0);
                end else begin
                    check("result", {out_tag, out_c}, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({in_tag, exp_c});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [4:0] b, input logic [1:0] aluc,
                         input logic [TAG_W-1:0] tag, input logic [31:0] expect_c);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_aluc  = aluc;
        in_tag   = tag;
        exp_c    = expect_c;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (!out_valid && count == 0) break;
            tick();
        end
        check("drain_ov", out_valid, 0);
        check("drain_q", exp_q.size(), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_aluc   = '0;
        in_tag    = '0;
        exp_c     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done_cnt, 0);
        check("rst_sh_a", sh_a, 0);
        rst_n = 1'b1;
        tick();

        // Single request: SLL by 4, 2-cycle latency
        drive(32'h00A5F0C3, 5'd4, 2'b10, 4'd1, 32'h0A5F0C30);
        tick();
        in_valid = 1'b0;
        check("single_count", count, 1);
        check("single_ov_early", out_valid, 0);
        check("single_head", sh_a, 32'h00A5F0C3);
        tick();
        check("single_ov", out_valid, 1);
        check("single_c", out_c, 32'h0A5F0C30);
        check("single_tag", out_tag, 1);
        check("single_count0", count, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_ov_clr", out_valid, 0);
        check("single_done", done_cnt, 1);

        // Backpressure: DEPTH + 1 requests fit before in_ready drops
        for (int t = 0; t < 5; t++) begin
            drive(32'h00A5F0C3, 5'd4, 2'b01, TAG_W'(t), 32'h000A5F0C);
            check("bp_ready", in_ready, 1);
            tick();
        end
        drive(32'h00A5F0C3, 5'd4, 2'b01, 4'd5, 32'h000A5F0C);
        check("bp_full_ready", in_ready, 0);
        check("bp_full_count", count, 4);
        check("bp_slot_tag", out_tag, 0);
        check("bp_slot_stable", out_c, 32'h000A5F0C);
        // Full with simultaneous pop: the offer is refused this edge, accepted the next
        out_ready = 1'b1;
        tick();
        check("fullpop_count", count, 3);
        check("fullpop_tag", out_tag, 1);
        check("fullpop_ready", in_ready, 1);
        tick();
        check("fullpop_accept_count", count, 3);
        drain();
        check("bp_done", done_cnt, 7);

        // Streaming with pointer wrap: SRA/SRL alternating, one result per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) drive(32'h80000000, 5'd4, 2'b00, TAG_W'(i), 32'hF8000000);
            else            drive(32'h80000000, 5'd4, 2'b01, TAG_W'(i), 32'h08000000);
            check("stream_ready", in_ready, 1);
            tick();
            check("stream_count", count, 1);
            check("stream_ov", out_valid, (i > 0) ? 1 : 0);
        end
        drain();
        check("stream_done", done_cnt, 17);

        // Flush priority over push, pop and load
        drive(32'h00000003, 5'd1, 2'b10, 4'd10, 32'h00000006);
        tick();
        drive(32'h00000003, 5'd2, 2'b10, 4'd11, 32'h0000000C);
        tick();
        drive(32'h00000003, 5'd3, 2'b10, 4'd12, 32'h00000018);
        tick();
        check("pre_flush_count", count, 2);
        check("pre_flush_ov", out_valid, 1);
        drive(32'hFFFFFFFF, 5'd0, 2'b10, 4'd15, 32'hFFFFFFFF);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        check("flush_count", count, 0);
        check("flush_ov", out_valid, 0);
        check("flush_done", done_cnt, 17);
        check("flush_ready", in_ready, 1);
        tick();
        tick();
        check("flush_no_ghost_ov", out_valid, 0);
        check("flush_no_ghost_cnt", count, 0);
        out_ready = 1'b0;

        // Asynchronous reset with 3 requests queued
        for (int t = 0; t < 3; t++) begin
            drive(32'h12345678, 5'd8, 2'b10, TAG_W'(t), 32'h34567800);
            tick();
        end
        in_valid = 1'b0;
        check("prerst_count", count, 2);
        check("prerst_ov", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_ov", out_valid, 0);
        check("arst_ready", in_ready, 1);
        check("arst_sh_a", sh_a, 0);
        check("arst_done", done_cnt, 0);
        check("arst_out_c", out_c, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Recovery after reset: SLL by 31
        drive(32'h00000001, 5'd31, 2'b11, 4'd7, 32'h80000000);
        tick();
        drain();
        check("recover_done", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
